// File: rtl/array_div8.sv
// array_div8 -- sequential restoring divider, unsigned operands.
// One quotient bit per clock. Operands enter through a start/busy/done
// handshake. Latency is WIDTH+2 cycles from the accepted start edge.
//
// Optional feature macro: ARRAY_DIV8_DBZ_EN
//   defined   : a zero divisor skips the iterations (done 2 cycles after
//               acceptance) and raises dbz with the result.
//   undefined : dbz is tied low; a zero divisor runs the normal algorithm.
//
// Ports
//   clk        clock, all registers update on the rising edge
//   rst        synchronous active-high reset
//   start      request a division, sampled only while busy=0
//   dividend   unsigned dividend, captured on the accepted start edge
//   divisor    unsigned divisor, captured on the accepted start edge
//   busy       high while a division is in progress
//   done       one-cycle pulse, quotient/remainder/dbz valid
//   quotient   result quotient, held until the next result
//   remainder  result remainder, held until the next result
//   dbz        divide-by-zero flag, valid with done
module array_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH:0]   p_q;      // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    // One restoring step: shift, trial subtract, keep on no borrow.
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   p_d;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        t    = p_sh - {1'b0, d_q};
        if (!t[WIDTH]) begin
            p_d = t;
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            p_d = p_sh;
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // A start is accepted in IDLE and also in the DONE cycle (busy is low
    // there), which gives back-to-back issue.
    logic accept;
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef ARRAY_DIV8_DBZ_EN
    logic dbz_q;
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef ARRAY_DIV8_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            // Operands are taken on the accepting edge itself, so the
            // inputs are free to change from the LOAD cycle onward.
            if (accept) begin
                state_q <= S_LOAD;
                p_q     <= '0;
                q_q     <= dividend;
                d_q     <= divisor;
                busy_q  <= 1'b1;
            end
            case (state_q)
                S_IDLE: done_q <= 1'b0;
                S_LOAD: begin
                    cnt_q <= CW'(WIDTH - 1);
`ifdef ARRAY_DIV8_DBZ_EN
                    if (d_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= '1;
                        rem_q   <= q_q;
                        dbz_q   <= 1'b1;
                    end else begin
                        state_q <= S_ITER;
                    end
`else
                    state_q <= S_ITER;
`endif
                end
                S_ITER: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    // The last step lands straight in the output registers.
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= p_d[WIDTH-1:0];
`ifdef ARRAY_DIV8_DBZ_EN
                        dbz_q   <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    if (!accept) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_array_div8.sv
module tb_array_div8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;

    int total = 0;
    int bad   = 0;
    logic [7:0] last_q = '0;
    logic [7:0] last_r = '0;

    array_div8 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Idle cycles: no done, results held.
    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("no_done", done, 0);
            chk("hold_q", quotient, last_q);
            chk("hold_r", remainder, last_r);
        end
    endtask

    // Issue a/b at the current negedge, wait for done, check against the
    // arithmetic model. inj>0 pulses a 9/3 start on that busy cycle.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input int inj);
        logic [7:0] eq, er;
        logic       ed;
        int lat, exp_lat;
        eq = (b == 0) ? 8'd255 : 8'(a / b);
        er = (b == 0) ? a : 8'(a % b);
        ed = 1'b0;
        exp_lat = 10;
`ifdef ARRAY_DIV8_DBZ_EN
        if (b == 0) begin
            exp_lat = 2;
            ed = 1'b1;
        end
`endif
        lat = 0;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (inj != 0 && c == inj) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                start = 1'b0;
                lat = c;
                break;
            end
            chk("busy", busy, 1);
            chk("hold_q_busy", quotient, last_q);
        end
        chk("latency", lat, exp_lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("dbz", dbz, ed);
        chk("busy_in_done", busy, 0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", dbz, 0);
        rst = 1'b0;
        quiet(2);

        // directed
        op(8'd100, 8'd7, 0);   quiet(1);
        op(8'd255, 8'd1, 0);   quiet(1);
        op(8'd0,   8'd9, 0);   quiet(1);
        op(8'd5,   8'd200, 0); quiet(1);
        op(8'd255, 8'd255, 0); quiet(1);
        op(8'd77,  8'd0, 0);   quiet(1);

        // start during busy is dropped
        op(8'd200, 8'd13, 3);
        quiet(15);

        // back-to-back: second start driven in the done cycle
        op(8'd100, 8'd7, 0);
        op(8'd50, 8'd4, 0);
        quiet(2);

        // reset mid-operation
        start = 1'b1; dividend = 8'd200; divisor = 8'd13;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        rst = 1'b0;
        last_q = '0; last_r = '0;
        quiet(15);
        op(8'd200, 8'd13, 0);
        quiet(1);

        // rst and start together: reset wins
        rst = 1'b1; start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", busy, 0);
        last_q = '0; last_r = '0;
        quiet(12);

        // random
        for (int i = 0; i < 200; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            op(a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
            if ($urandom_range(0, 1) == 1) quiet($urandom_range(1, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
